// File: rtl/dispatch_wide.sv
// N-wide in-order dispatch with internal RS credits and checkpoint accounting; outputs registered (1 cycle).
// Optional stall counters enabled by DISPATCH_PERF_CNT_EN.
module dispatch_wide #(
  parameter int WIDTH        = 2,
  parameter int ALU_RS_DEPTH = 8,
  parameter int BR_RS_DEPTH  = 4,
  parameter int LSU_RS_DEPTH = 8,
  parameter int NUM_CKPT     = 4,
  parameter int ROB_BITS     = 4,
  parameter int PAYLOAD_W    = 8,
  // renamed_instr_t layout, LSB first: rob_tag, fu_type[1:0], is_branch, payload
  localparam int INSTR_W     = ROB_BITS + 3 + PAYLOAD_W,
  localparam int CNT_W       = $clog2(WIDTH + 1)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [WIDTH*INSTR_W-1:0]    instr_in,
  input  logic [WIDTH-1:0]            valid_in,
  output logic [CNT_W-1:0]            dispatch_count,
  input  logic [ROB_BITS:0]           rob_free_count,
  output logic [WIDTH-1:0]            rob_alloc_en,
  output logic [WIDTH*ROB_BITS-1:0]   rob_alloc_tag,
  output logic [WIDTH*INSTR_W-1:0]    rob_alloc_instr,
  output logic [WIDTH-1:0]            rob_store_checkpoint,
  output logic [WIDTH-1:0]            dispatch_alu_en,
  output logic [WIDTH-1:0]            dispatch_branch_en,
  output logic [WIDTH-1:0]            dispatch_lsu_en,
  output logic [WIDTH*INSTR_W-1:0]    dispatch_alu_instr,
  output logic [WIDTH*INSTR_W-1:0]    dispatch_branch_instr,
  output logic [WIDTH*INSTR_W-1:0]    dispatch_lsu_instr,
  input  logic                        rs_alu_release,
  input  logic                        rs_branch_release,
  input  logic                        rs_lsu_release,
  input  logic                        ckpt_release,
  input  logic                        flush
`ifdef DISPATCH_PERF_CNT_EN
  ,
  output logic [31:0]                 stall_rob_cnt,
  output logic [31:0]                 stall_rs_cnt,
  output logic [31:0]                 stall_ckpt_cnt
`endif
);

  localparam int ALU_CW  = $clog2(ALU_RS_DEPTH + 1);
  localparam int BR_CW   = $clog2(BR_RS_DEPTH + 1);
  localparam int LSU_CW  = $clog2(LSU_RS_DEPTH + 1);
  localparam int CKPT_CW = $clog2(NUM_CKPT + 1);

  localparam logic [1:0] FU_ALU = 2'd0;
  localparam logic [1:0] FU_BR  = 2'd1;
  localparam logic [1:0] FU_LSU = 2'd2;

  logic [ALU_CW-1:0]  alu_credit;
  logic [BR_CW-1:0]   br_credit;
  logic [LSU_CW-1:0]  lsu_credit;
  logic [CKPT_CW-1:0] ckpt_used;

  logic [1:0] lane_fu [WIDTH];
  logic       lane_br [WIDTH];
  logic [WIDTH-1:0] grant;

  int n_alu, n_br, n_lsu, n_ckpt, n_grant, alloc_pend, rob_avail;
  int alu_next, br_next, lsu_next, ckpt_next;
  logic stop, rob_ok, rs_ok, ckpt_ok, lane_live;

`ifdef DISPATCH_PERF_CNT_EN
  logic [1:0] blk_cause;
  localparam logic [1:0] CAUSE_NONE = 2'd0;
  localparam logic [1:0] CAUSE_ROB  = 2'd1;
  localparam logic [1:0] CAUSE_RS   = 2'd2;
  localparam logic [1:0] CAUSE_CKPT = 2'd3;
`endif

  for (genvar g = 0; g < WIDTH; g++) begin : g_lane
    assign lane_fu[g] = instr_in[g*INSTR_W+ROB_BITS +: 2];
    assign lane_br[g] = instr_in[g*INSTR_W+ROB_BITS+2];
  end

  // Prefix grant: per-FU counts of older granted lanes are consumed against credit as we walk.
  always_comb begin
    grant      = '0;
    n_alu      = 0;
    n_br       = 0;
    n_lsu      = 0;
    n_ckpt     = 0;
    n_grant    = 0;
    stop       = 1'b0;
    rob_ok     = 1'b0;
    rs_ok      = 1'b0;
    ckpt_ok    = 1'b0;
    lane_live  = 1'b0;
    alloc_pend = 0;
`ifdef DISPATCH_PERF_CNT_EN
    blk_cause  = CAUSE_NONE;
`endif
    for (int i = 0; i < WIDTH; i++) alloc_pend += int'(rob_alloc_en[i]);
    rob_avail = int'(rob_free_count) - alloc_pend;
    if (rob_avail < 0) rob_avail = 0;
    for (int i = 0; i < WIDTH; i++) begin
      rob_ok = rob_avail > i;
      case (lane_fu[i])
        FU_ALU:  rs_ok = int'(alu_credit) > n_alu;
        FU_BR:   rs_ok = int'(br_credit) > n_br;
        FU_LSU:  rs_ok = int'(lsu_credit) > n_lsu;
        default: rs_ok = 1'b0;
      endcase
      ckpt_ok   = !lane_br[i] || ((int'(ckpt_used) + n_ckpt) < NUM_CKPT);
      lane_live = !stop && valid_in[i] && rst_n && !flush;
      if (lane_live && rob_ok && rs_ok && ckpt_ok) begin
        grant[i] = 1'b1;
        n_grant++;
        if (lane_fu[i] == FU_ALU) n_alu++;
        if (lane_fu[i] == FU_BR)  n_br++;
        if (lane_fu[i] == FU_LSU) n_lsu++;
        if (lane_br[i])           n_ckpt++;
      end else begin
`ifdef DISPATCH_PERF_CNT_EN
        if (lane_live)
          blk_cause = !rob_ok ? CAUSE_ROB : (!rs_ok ? CAUSE_RS : CAUSE_CKPT);
`endif
        stop = 1'b1;
      end
    end

    alu_next  = int'(alu_credit) - n_alu +
                ((rs_alu_release && alu_credit != ALU_CW'(ALU_RS_DEPTH)) ? 1 : 0);
    br_next   = int'(br_credit) - n_br +
                ((rs_branch_release && br_credit != BR_CW'(BR_RS_DEPTH)) ? 1 : 0);
    lsu_next  = int'(lsu_credit) - n_lsu +
                ((rs_lsu_release && lsu_credit != LSU_CW'(LSU_RS_DEPTH)) ? 1 : 0);
    ckpt_next = int'(ckpt_used) + n_ckpt - int'(ckpt_release);
    if (ckpt_next < 0)        ckpt_next = 0;
    if (ckpt_next > NUM_CKPT) ckpt_next = NUM_CKPT;
  end

  assign dispatch_count = CNT_W'(n_grant);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_credit <= ALU_CW'(ALU_RS_DEPTH);
      br_credit  <= BR_CW'(BR_RS_DEPTH);
      lsu_credit <= LSU_CW'(LSU_RS_DEPTH);
      ckpt_used  <= '0;
    end else if (flush) begin
      alu_credit <= ALU_CW'(ALU_RS_DEPTH);
      br_credit  <= BR_CW'(BR_RS_DEPTH);
      lsu_credit <= LSU_CW'(LSU_RS_DEPTH);
      ckpt_used  <= '0;
    end else begin
      alu_credit <= ALU_CW'(alu_next);
      br_credit  <= BR_CW'(br_next);
      lsu_credit <= LSU_CW'(lsu_next);
      ckpt_used  <= CKPT_CW'(ckpt_next);
    end
  end

  // Flush already suppresses every grant, so the en bits clear on the flush edge without extra terms.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rob_alloc_en          <= '0;
      rob_alloc_tag         <= '0;
      rob_alloc_instr       <= '0;
      rob_store_checkpoint  <= '0;
      dispatch_alu_en       <= '0;
      dispatch_branch_en    <= '0;
      dispatch_lsu_en       <= '0;
      dispatch_alu_instr    <= '0;
      dispatch_branch_instr <= '0;
      dispatch_lsu_instr    <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        rob_alloc_en[i]         <= grant[i];
        rob_store_checkpoint[i] <= grant[i] && lane_br[i];
        dispatch_alu_en[i]      <= grant[i] && (lane_fu[i] == FU_ALU);
        dispatch_branch_en[i]   <= grant[i] && (lane_fu[i] == FU_BR);
        dispatch_lsu_en[i]      <= grant[i] && (lane_fu[i] == FU_LSU);
        if (grant[i]) begin
          rob_alloc_tag[i*ROB_BITS +: ROB_BITS] <= instr_in[i*INSTR_W +: ROB_BITS];
          rob_alloc_instr[i*INSTR_W +: INSTR_W] <= instr_in[i*INSTR_W +: INSTR_W];
          if (lane_fu[i] == FU_ALU)
            dispatch_alu_instr[i*INSTR_W +: INSTR_W] <= instr_in[i*INSTR_W +: INSTR_W];
          if (lane_fu[i] == FU_BR)
            dispatch_branch_instr[i*INSTR_W +: INSTR_W] <= instr_in[i*INSTR_W +: INSTR_W];
          if (lane_fu[i] == FU_LSU)
            dispatch_lsu_instr[i*INSTR_W +: INSTR_W] <= instr_in[i*INSTR_W +: INSTR_W];
        end
      end
    end
  end

`ifdef DISPATCH_PERF_CNT_EN
  // A stall cause is only recorded for the first ungranted lane when it is valid, which
  // already implies fewer grants than valid lanes and a valid lane 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_rob_cnt  <= '0;
      stall_rs_cnt   <= '0;
      stall_ckpt_cnt <= '0;
    end else begin
      if (valid_in[0] && blk_cause == CAUSE_ROB)  stall_rob_cnt  <= stall_rob_cnt + 32'd1;
      if (valid_in[0] && blk_cause == CAUSE_RS)   stall_rs_cnt   <= stall_rs_cnt + 32'd1;
      if (valid_in[0] && blk_cause == CAUSE_CKPT) stall_ckpt_cnt <= stall_ckpt_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dispatch_wide.sv
// Directed bench for dispatch_wide (WIDTH=2): grants, credits, checkpoints, ROB space, flush and async reset.
module tb_dispatch_wide;
  localparam int W  = 2;
  localparam int IW = 15;

  localparam logic [1:0] ALU = 2'd0;
  localparam logic [1:0] BR  = 2'd1;
  localparam logic [1:0] LSU = 2'd2;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [W*IW-1:0] instr_in;
  logic [W-1:0]    valid_in;
  logic [1:0]      dispatch_count;
  logic [4:0]      rob_free_count;
  logic [W-1:0]    rob_alloc_en;
  logic [W*4-1:0]  rob_alloc_tag;
  logic [W*IW-1:0] rob_alloc_instr;
  logic [W-1:0]    rob_store_checkpoint;
  logic [W-1:0]    dispatch_alu_en, dispatch_branch_en, dispatch_lsu_en;
  logic [W*IW-1:0] dispatch_alu_instr, dispatch_branch_instr, dispatch_lsu_instr;
  logic            rs_alu_release, rs_branch_release, rs_lsu_release, ckpt_release, flush;
`ifdef DISPATCH_PERF_CNT_EN
  logic [31:0]     stall_rob_cnt, stall_rs_cnt, stall_ckpt_cnt;
`endif

  int vecs = 0;
  int errs = 0;

  dispatch_wide #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .instr_in(instr_in), .valid_in(valid_in),
    .dispatch_count(dispatch_count), .rob_free_count(rob_free_count),
    .rob_alloc_en(rob_alloc_en), .rob_alloc_tag(rob_alloc_tag), .rob_alloc_instr(rob_alloc_instr),
    .rob_store_checkpoint(rob_store_checkpoint),
    .dispatch_alu_en(dispatch_alu_en), .dispatch_branch_en(dispatch_branch_en),
    .dispatch_lsu_en(dispatch_lsu_en), .dispatch_alu_instr(dispatch_alu_instr),
    .dispatch_branch_instr(dispatch_branch_instr), .dispatch_lsu_instr(dispatch_lsu_instr),
    .rs_alu_release(rs_alu_release), .rs_branch_release(rs_branch_release),
    .rs_lsu_release(rs_lsu_release), .ckpt_release(ckpt_release), .flush(flush)
`ifdef DISPATCH_PERF_CNT_EN
    , .stall_rob_cnt(stall_rob_cnt), .stall_rs_cnt(stall_rs_cnt), .stall_ckpt_cnt(stall_ckpt_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [IW-1:0] mk(input logic [1:0] fu, input logic br, input logic [3:0] tag);
    return {4'hA, tag, br, fu, tag};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic credits(input string tag, input int a, input int b, input int l, input int c);
    chk({tag, "_alu_cr"},  64'(dut.alu_credit), 64'(a));
    chk({tag, "_br_cr"},   64'(dut.br_credit),  64'(b));
    chk({tag, "_lsu_cr"},  64'(dut.lsu_credit), 64'(l));
    chk({tag, "_ckpt"},    64'(dut.ckpt_used),  64'(c));
  endtask

  logic [IW-1:0] l0, l1;

  initial begin
    rst_n = 1'b0;
    rs_alu_release = 0; rs_branch_release = 0; rs_lsu_release = 0; ckpt_release = 0; flush = 0;
    rob_free_count = 5'd16;
    instr_in = {mk(ALU, 0, 4'd2), mk(ALU, 0, 4'd1)};
    valid_in = 2'b11;
    #12;
    chk("rst_count", 64'(dispatch_count), 64'd0);
    chk("rst_alloc_en", 64'(rob_alloc_en), 64'd0);
    chk("rst_alu_en", 64'(dispatch_alu_en), 64'd0);
    credits("rst", 8, 4, 8, 0);
    valid_in = 2'b00;
    rst_n = 1'b1;
    tick();

    // {ALU tag3, LSU tag4}
    l0 = mk(ALU, 0, 4'd3); l1 = mk(LSU, 0, 4'd4);
    instr_in = {l1, l0}; valid_in = 2'b11; #1;
    chk("s1_count", 64'(dispatch_count), 64'd2);
    tick();
    valid_in = 2'b00;
    chk("s1_alu_en", 64'(dispatch_alu_en), 64'b01);
    chk("s1_lsu_en", 64'(dispatch_lsu_en), 64'b10);
    chk("s1_br_en", 64'(dispatch_branch_en), 64'b00);
    chk("s1_alloc_en", 64'(rob_alloc_en), 64'b11);
    chk("s1_tag", 64'(rob_alloc_tag), 64'h43);
    chk("s1_rob_instr", 64'(rob_alloc_instr), 64'({l1, l0}));
    chk("s1_alu_instr", 64'(dispatch_alu_instr[IW-1:0]), 64'(l0));
    chk("s1_lsu_instr", 64'(dispatch_lsu_instr[2*IW-1:IW]), 64'(l1));
    credits("s1", 7, 4, 7, 0);

    // two branches; release at full branch credit is ignored
    instr_in = {mk(BR, 1, 4'd6), mk(BR, 1, 4'd5)}; valid_in = 2'b11; rs_branch_release = 1; #1;
    chk("s2_count", 64'(dispatch_count), 64'd2);
    tick();
    chk("s2_br_en", 64'(dispatch_branch_en), 64'b11);
    chk("s2_ckpt_store", 64'(rob_store_checkpoint), 64'b11);
    chk("s2_alu_en", 64'(dispatch_alu_en), 64'b00);
    credits("s2", 7, 2, 7, 2);

    // grant and release together
    instr_in = {mk(BR, 1, 4'd8), mk(BR, 1, 4'd7)}; #1;
    chk("s3_count", 64'(dispatch_count), 64'd2);
    tick();
    rs_branch_release = 0;
    credits("s3", 7, 1, 7, 4);

    // checkpoints exhausted: branch blocks the younger ALU
    instr_in = {mk(ALU, 0, 4'd10), mk(BR, 1, 4'd9)}; #1;
    chk("s4_count", 64'(dispatch_count), 64'd0);
    tick();
    chk("s4_alloc_en", 64'(rob_alloc_en), 64'b00);

    instr_in = {mk(BR, 1, 4'd10), mk(ALU, 0, 4'd9)}; #1;
    chk("s5_count", 64'(dispatch_count), 64'd1);
    tick();
    chk("s5_alu_en", 64'(dispatch_alu_en), 64'b01);
    valid_in = 2'b00; ckpt_release = 1;
    tick();
    ckpt_release = 0;
    credits("s6", 6, 1, 7, 3);

    // one checkpoint left but branch RS credit only covers lane 0
    instr_in = {mk(BR, 1, 4'd12), mk(BR, 1, 4'd11)}; valid_in = 2'b11; #1;
    chk("s7_count", 64'(dispatch_count), 64'd1);
    tick();
    chk("s7_ckpt_store", 64'(rob_store_checkpoint), 64'b01);
    credits("s7", 6, 0, 7, 4);

    // ALU drain from 6
    instr_in = {mk(ALU, 0, 4'd14), mk(ALU, 0, 4'd13)}; #1;
    chk("s8_count", 64'(dispatch_count), 64'd2);
    tick();
    rs_alu_release = 1; #1;
    chk("s9_count", 64'(dispatch_count), 64'd2);
    tick();
    rs_alu_release = 0;
    chk("s9_alu_cr", 64'(dut.alu_credit), 64'd3);
    tick();
    chk("s10_alu_cr", 64'(dut.alu_credit), 64'd1);
    chk("s11_count", 64'(dispatch_count), 64'd1);
    tick();
    chk("s11_alu_en", 64'(dispatch_alu_en), 64'b01);
    chk("s11_alloc_en", 64'(rob_alloc_en), 64'b01);
    chk("s11_alu_cr", 64'(dut.alu_credit), 64'd0);
    rs_alu_release = 1; #1;
    chk("s12_count", 64'(dispatch_count), 64'd0);
    tick();
    rs_alu_release = 0; #1;
    chk("s13_count", 64'(dispatch_count), 64'd1);
    tick();
    chk("s13_alu_cr", 64'(dut.alu_credit), 64'd0);
    valid_in = 2'b00;
    tick();

    // ROB space: pending allocation in the output register counts against free entries
    rob_free_count = 5'd1;
    instr_in = {mk(LSU, 0, 4'd2), mk(LSU, 0, 4'd1)}; valid_in = 2'b11; #1;
    chk("s15_count", 64'(dispatch_count), 64'd1);
    tick();
    chk("s16_count", 64'(dispatch_count), 64'd0);
    tick();
    chk("s16_alloc_en", 64'(rob_alloc_en), 64'b00);
    chk("s16_lsu_cr", 64'(dut.lsu_credit), 64'd6);

    // flush overrides releases and wipes en/credits/checkpoints
    rob_free_count = 5'd16; #1;
    chk("s18_count", 64'(dispatch_count), 64'd2);
    tick();
    chk("s18_lsu_en", 64'(dispatch_lsu_en), 64'b11);
    flush = 1; rs_alu_release = 1; rs_lsu_release = 1; ckpt_release = 1; #1;
    chk("s19_count", 64'(dispatch_count), 64'd0);
    tick();
    flush = 0; rs_alu_release = 0; rs_lsu_release = 0;
    chk("s19_lsu_en", 64'(dispatch_lsu_en), 64'b00);
    chk("s19_alloc_en", 64'(rob_alloc_en), 64'b00);
    credits("s19", 8, 4, 8, 0);
    valid_in = 2'b00;
    tick();
    ckpt_release = 0;
    chk("s20_ckpt_sat", 64'(dut.ckpt_used), 64'd0);

    // async reset mid-burst
    instr_in = {mk(ALU, 0, 4'd2), mk(ALU, 0, 4'd1)}; valid_in = 2'b11; #1;
    chk("s21_count", 64'(dispatch_count), 64'd2);
    tick();
    chk("s21_alu_en", 64'(dispatch_alu_en), 64'b11);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_alu_en", 64'(dispatch_alu_en), 64'b00);
    chk("arst_alloc_en", 64'(rob_alloc_en), 64'b00);
    chk("arst_tag", 64'(rob_alloc_tag), 64'h0);
    chk("arst_count", 64'(dispatch_count), 64'd0);
    credits("arst", 8, 4, 8, 0);
    #10 rst_n = 1'b1;
    valid_in = 2'b00;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/dispatch_wide.md
Name: dispatch_wide

Overview:
- N-wide, credit-based successor to the single-lane dispatch router. Sits between the rename/dispatch buffer and the ROB plus the ALU/BRANCH/LSU reservation stations.
- Grants an in-order prefix of up to WIDTH renamed instructions per cycle. Tracks RS occupancy and branch checkpoint usage internally, so it does not rely on combinational full flags.
- Registers all ROB/RS write outputs; they take effect 1 cycle after the grant.

Parameters:
- WIDTH, 2, dispatch lanes per cycle (1..4).
- ALU_RS_DEPTH, 8, ALU RS entries; initial and post-flush ALU credit.
- BR_RS_DEPTH, 4, Branch RS entries.
- LSU_RS_DEPTH, 8, LSU RS entries.
- NUM_CKPT, 4, maximum outstanding branch checkpoints.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- instr_in  in  WIDTH x renamed_instr_t  lane 0 is oldest.
- valid_in  in  WIDTH  per-lane valid.
- dispatch_count  out  $clog2(WIDTH+1)  lanes consumed this cycle (combinational); buffer pops this many.
- rob_free_count  in  ROB_BITS+1  free ROB entries reported by the ROB.
- rob_alloc_en  out  WIDTH  registered ROB allocate.
- rob_alloc_tag  out  WIDTH x ROB_BITS  registered, equals instr.rob_tag.
- rob_alloc_instr  out  WIDTH x renamed_instr_t  registered.
- rob_store_checkpoint  out  WIDTH  registered; set for granted lanes with is_branch.
- dispatch_{alu,branch,lsu}_en  out  WIDTH  registered per-lane RS write enable.
- dispatch_{alu,branch,lsu}_instr  out  WIDTH x renamed_instr_t  registered.
- rs_{alu,branch,lsu}_release  in  1 each  one RS entry freed this cycle (issue).
- ckpt_release  in  1  one checkpoint freed (branch resolved or committed).
- flush  in  1  pipeline flush.

Behaviour:
- Reset (rst_n=0, asynchronous): all en/checkpoint outputs=0, instr/tag outputs=0, credits=DEPTHs, ckpt_used=0. dispatch_count=0 while reset is asserted.
- Effective ROB space: rob_avail = rob_free_count − popcount(rob_alloc_en). This accounts for allocations still in the output register. Saturate at 0.
- Lane i grant requires all of the following:
  - valid_in[i].
  - Lanes 0..i−1 all granted (strict in-order prefix; an invalid or blocked lane stops all younger lanes).
  - rob_avail > i.
  - Credit of the target FU > number of older granted lanes with the same fu_type.
  - If is_branch: ckpt_used + older granted branches < NUM_CKPT.
  - flush=0.
- dispatch_count = number of granted lanes. It is combinational from the inputs and current state.
- Output register on each posedge:
  - Granted lanes latch instr_in[i] into rob_alloc_* and the matching FU port.
  - Other lanes' en bits clear to 0; their instr fields hold.
  - Exactly one of alu/branch/lsu en is set per granted lane.
- Credit update per FU: credit_next = credit − granted_count(FU) + release. Release with credit==DEPTH is ignored (saturate). A release and a grant in the same cycle both apply.
- ckpt_used_next = ckpt_used + granted branches − ckpt_release, saturating at 0 and NUM_CKPT.
- Flush:
  - Grants are suppressed in the flush cycle.
  - On the edge: all en outputs clear, credits go to DEPTHs, ckpt_used=0.
  - Flush overrides simultaneous release/ckpt_release.
  - Register contents latched before the flush edge still present for that one cycle. The RS/ROB flush the same cycle, so this is harmless.
- Unknown fu_type: lane blocks (treated as no credit). This guarantees it is never silently dropped.
- Invariant (for assertions): 0 ≤ credit ≤ DEPTH; 0 ≤ ckpt_used ≤ NUM_CKPT.

Optional Feature:
- Macro DISPATCH_PERF_CNT_EN. When defined, adds out ports stall_rob_cnt, stall_rs_cnt, stall_ckpt_cnt (32 bits each).
  - Each increments once per cycle in which valid_in[0]=1, dispatch_count<popcount(valid_in), and the first blocked lane's limiting cause is ROB, RS credit, or checkpoint respectively. Priority is ROB > RS > ckpt.
  - Counters wrap, clear on reset, and are unaffected by flush.
- Undefined: ports and counters are absent; no other behaviour changes.

Test Plan:
- Reset, then WIDTH=2 with lanes {ALU tag3, LSU tag4} valid, rob_free_count=16 → dispatch_count=2. Next cycle: dispatch_alu_en=01, dispatch_lsu_en=10, rob_alloc_tag={4,3}, and ALU/LSU credits become 7.
- Issue 8 back-to-back ALU-only grants with no release → ALU credit 0; the next ALU lane is blocked (dispatch_count=0). Pulse rs_alu_release → the next cycle grants 1.
- Lanes {ALU, ALU}, ALU credit=1 → dispatch_count=1, and only lane 0 is written.
- Lanes {BRANCH, ALU}, ckpt_used=NUM_CKPT=4 → dispatch_count=0. This checks in-order blocking of the younger ALU.
- rob_free_count=1 held constant for 2 cycles with ALU lanes valid → cycle 1 grants 1. Cycle 2 sees rob_avail=0 because one allocation is still in the output register, so it grants 0.
- Drain credits to ALU=2 and ckpt_used=3, then assert flush together with a release → the flush cycle grants 0. The next cycle shows credits 8/4/8, ckpt_used=0, and all en outputs 0. Asserting rst_n=0 mid-burst clears the outputs immediately, without waiting for a clock edge.
